// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// One client port of the two-port memory arbiter.
//   req    client asks for one memory access (held stable until gnt)
//   we     1 = write, 0 = read
//   addr   byte address
//   wdata  write data
//   lock   client wants to keep ownership on following cycles
//   gnt    access performed for this port this cycle (combinational)
//   rdata  registered read data
//   rvalid one-cycle pulse, rdata was updated
// Modports: master = client side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       lock;
  logic       gnt;
  logic [7:0] rdata;
  logic       rvalid;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single-port data memory with combinational
// read. Round-robin between the ports, with an optional lock that lets one
// port keep ownership for up to MAX_LOCK consecutive grants.
//
// Ports
//   clk          sole clock, all state on its rising edge
//   reset        asynchronous, active-high
//   p0, p1       client ports (mem_arbiter_if.slave)
//   mem_addr     address to data memory (granted port, port0 when idle)
//   mem_dat_in   write data to data memory (granted port, port0 when idle)
//   mem_wr_en    write enable to data memory, write lands on the next edge
//   mem_dat_out  combinational read data from data memory
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  mem_arbiter_if.slave p0,
  mem_arbiter_if.slave p1,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_dat_in,
  output logic        mem_wr_en,
  input  logic [7:0]  mem_dat_out
);

  // Counter must hold MAX_LOCK and is never narrower than 3 bits.
  localparam int CNT_W = ($clog2(MAX_LOCK + 1) > 3) ? $clog2(MAX_LOCK + 1) : 3;
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } fsm_t;

  fsm_t             fsm_reg;
  logic             pri_reg;       // port favoured on the next contested cycle
  logic [CNT_W-1:0] lock_cnt_reg;  // consecutive grants of the current owner

  logic [1:0] req;
  logic [1:0] we;
  logic [1:0] lock;
  logic [1:0] hold;
  logic [1:0] gnt;
  logic       gnt_lock;
  fsm_t       owner_next;

  logic [1:0][7:0] rdata_bus;
  logic [1:0]      rvalid_bus;

  assign req  = {p1.req,  p0.req};
  assign we   = {p1.we,   p0.we};
  assign lock = {p1.lock, p0.lock};

  // An owner that still requests with lock and has budget left keeps the
  // memory no matter what the other port does. Only one can be the owner.
  assign hold[0] = (fsm_reg == OWN0) && req[0] && lock[0] && (lock_cnt_reg < LOCK_MAX);
  assign hold[1] = (fsm_reg == OWN1) && req[1] && lock[1] && (lock_cnt_reg < LOCK_MAX);

  // Grant decision. Reset forces no grant combinationally so nothing reaches
  // the memory while reset is asserted. An expired lock or an owner that
  // dropped its request falls straight through to round-robin, so there is
  // never a dead cycle.
  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      gnt = 2'b00;
    end else if (hold[0]) begin
      gnt = 2'b01;
    end else if (hold[1]) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      gnt = pri_reg ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  assign gnt_lock   = gnt[1] ? lock[1] : lock[0];
  assign owner_next = gnt[1] ? OWN1 : OWN0;

  // Ownership / round-robin state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg      <= IDLE;
      pri_reg      <= 1'b0;
      lock_cnt_reg <= '0;
    end else if (|gnt) begin
      // The port just served is disfavoured next time.
      pri_reg <= ~gnt[1];
      if (gnt_lock) begin
        fsm_reg <= owner_next;
        if (fsm_reg == owner_next) begin
          // Same owner continuing: count up, saturating at the budget.
          lock_cnt_reg <= (lock_cnt_reg >= LOCK_MAX) ? LOCK_MAX
                                                     : lock_cnt_reg + 1'b1;
        end else begin
          lock_cnt_reg <= CNT_W'(1);
        end
      end else begin
        fsm_reg      <= IDLE;
        lock_cnt_reg <= '0;
      end
    end else begin
      fsm_reg      <= IDLE;
      lock_cnt_reg <= '0;
    end
  end

  // Memory side mux: port0 values are presented whenever port1 is not granted.
  assign mem_addr   = gnt[1] ? p1.addr  : p0.addr;
  assign mem_dat_in = gnt[1] ? p1.wdata : p0.wdata;
  assign mem_wr_en  = |(gnt & we);

  // Per-port read return: capture memory data on a read grant, pulse rvalid
  // for exactly the following cycle, otherwise keep the last read value.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [7:0] rdata_reg;
      logic       rvalid_reg;
      logic       rd_hit;

      assign rd_hit = gnt[gi] & ~we[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_reg  <= 8'h00;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= rd_hit;
          if (rd_hit) begin
            rdata_reg <= mem_dat_out;
          end
        end
      end

      assign rdata_bus[gi]  = rdata_reg;
      assign rvalid_bus[gi] = rvalid_reg;
    end
  endgenerate

  assign p0.gnt    = gnt[0];
  assign p1.gnt    = gnt[1];
  assign p0.rdata  = rdata_bus[0];
  assign p1.rdata  = rdata_bus[1];
  assign p0.rvalid = rvalid_bus[0];
  assign p1.rvalid = rvalid_bus[1];

endmodule
